// File: rtl/conv_acc_out_framer.sv
// Re-frames the conv accelerator output stream into per-row bursts for the store DMA.
// TLAST/TUSER are regenerated from local counters; a small FIFO absorbs DMA back-pressure.
module conv_acc_out_framer #(
  parameter int DATA_WIDTH      = 32,
  parameter int WORDS_PER_PIXEL = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_out_width,
  input  logic [CNT_WIDTH-1:0]  cfg_out_rows,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  m_axis_tready,
  output logic                  busy,
  output logic                  done,
  output logic                  err_tlast,
  output logic [CNT_WIDTH-1:0]  row_count
);

  localparam int WW = (WORDS_PER_PIXEL > 1) ? $clog2(WORDS_PER_PIXEL) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int EW = DATA_WIDTH + 2;

  localparam logic [WW-1:0]        WORD_LAST = WW'(WORDS_PER_PIXEL - 1);
  localparam logic [WW-1:0]        WORD_ONE  = WW'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [PW-1:0]        PTR_ONE   = PW'(1);
  localparam logic [PW:0]          OCC_ONE   = (PW+1)'(1);
  localparam logic [PW:0]          OCC_FULL  = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t               state_reg;
  logic [CNT_WIDTH-1:0] width_reg;
  logic [CNT_WIDTH-1:0] rows_reg;
  logic [WW-1:0]        word_cnt_reg;
  logic [CNT_WIDTH-1:0] pix_cnt_reg;
  logic [CNT_WIDTH-1:0] row_cnt_reg;
  logic [CNT_WIDTH-1:0] row_count_reg;
  logic                 first_reg;
  logic                 err_reg;

  logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_reg;
  logic [PW-1:0]        rd_ptr_reg;
  logic [PW:0]          occ_reg;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic                 pix_end;
  logic                 row_end;
  logic                 layer_end;
  logic                 cfg_zero;
  logic                 drain_empty;
  logic [EW-1:0]        head;

  assign fifo_full   = (occ_reg == OCC_FULL);
  assign fifo_empty  = (occ_reg == '0);
  assign s_axis_tready = (state_reg == ST_RUN) && !fifo_full;
  assign push        = s_axis_tvalid && s_axis_tready;
  assign pop         = m_axis_tvalid && m_axis_tready;

  assign pix_end     = (word_cnt_reg == WORD_LAST);
  assign row_end     = pix_end && (pix_cnt_reg == width_reg - CNT_ONE);
  assign layer_end   = row_end && (row_cnt_reg == rows_reg - CNT_ONE);
  assign cfg_zero    = (cfg_out_width == '0) || (cfg_out_rows == '0);
  // The last word may leave this very cycle; finish without an extra idle beat.
  assign drain_empty = fifo_empty || ((occ_reg == OCC_ONE) && pop);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_reg     <= ST_IDLE;
      width_reg     <= '0;
      rows_reg      <= '0;
      word_cnt_reg  <= '0;
      pix_cnt_reg   <= '0;
      row_cnt_reg   <= '0;
      row_count_reg <= '0;
      first_reg     <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            width_reg     <= cfg_out_width;
            rows_reg      <= cfg_out_rows;
            word_cnt_reg  <= '0;
            pix_cnt_reg   <= '0;
            row_cnt_reg   <= '0;
            row_count_reg <= '0;
            first_reg     <= 1'b1;
            err_reg       <= 1'b0;
            state_reg     <= cfg_zero ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (push) begin
            first_reg <= 1'b0;
            if (s_axis_tlast != row_end)
              err_reg <= 1'b1;
            if (pix_end) begin
              word_cnt_reg <= '0;
              if (row_end) begin
                pix_cnt_reg   <= '0;
                row_count_reg <= row_count_reg + CNT_ONE;
                row_cnt_reg   <= layer_end ? '0 : row_cnt_reg + CNT_ONE;
              end else begin
                pix_cnt_reg <= pix_cnt_reg + CNT_ONE;
              end
            end else begin
              word_cnt_reg <= word_cnt_reg + WORD_ONE;
            end
            if (layer_end)
              state_reg <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_empty)
            state_reg <= ST_DONE;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // Occupancy and pointers; a push and a pop in the same cycle cancel out.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      occ_reg    <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push, pop})
        2'b10:   occ_reg <= occ_reg + OCC_ONE;
        2'b01:   occ_reg <= occ_reg - OCC_ONE;
        default: occ_reg <= occ_reg;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (push)
      fifo_mem[wr_ptr_reg] <= {s_axis_tdata, row_end, first_reg};
  end

  // Stale entries are masked so the master side reads all-zero whenever nothing is offered.
  assign head          = fifo_mem[rd_ptr_reg];
  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = m_axis_tvalid ? head[EW-1:2] : '0;
  assign m_axis_tlast  = m_axis_tvalid && head[1];
  assign m_axis_tuser  = m_axis_tvalid && head[0];

  assign busy      = (state_reg != ST_IDLE);
  assign done      = (state_reg == ST_DONE);
  assign err_tlast = err_reg;
  assign row_count = row_count_reg;

endmodule
